// File: rtl/warp_writeback_collector.sv
// Warp writeback collector: gathers per-lane core completions against an in-order
// dispatch tag FIFO and presents one warp-wide result per tag to the register file.
module warp_writeback_collector #(
    parameter int unsigned NUM_THREADS = 32,
    parameter int unsigned W           = 32,
    parameter int unsigned WARP_ID_W   = 5,
    parameter int unsigned REG_W       = 6,
    parameter int unsigned TAG_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tag_valid,
    output logic                          tag_ready,
    input  logic [WARP_ID_W-1:0]          tag_warp_id,
    input  logic [REG_W-1:0]              tag_dest_reg,
    input  logic [NUM_THREADS-1:0]        tag_mask,
    input  logic [NUM_THREADS-1:0]        core_done,
    input  logic [NUM_THREADS*W-1:0]      core_result,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [WARP_ID_W-1:0]          wb_warp_id,
    output logic [REG_W-1:0]              wb_dest_reg,
    output logic [NUM_THREADS-1:0]        wb_mask,
    output logic [NUM_THREADS*W-1:0]      wb_data,
    output logic                          collect_hold,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan,
    output logic                          err_dup
);

    localparam int unsigned PTR_W  = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W  = $clog2(TAG_DEPTH) + 1;
    localparam int unsigned DATA_W = NUM_THREADS * W;

    // Tag FIFO storage and pointers
    logic [WARP_ID_W-1:0]   warp_mem [TAG_DEPTH];
    logic [REG_W-1:0]       reg_mem  [TAG_DEPTH];
    logic [NUM_THREADS-1:0] mask_mem [TAG_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    // Collection state for the head tag
    logic [DATA_W-1:0]      coll_buf;
    logic [NUM_THREADS-1:0] collected;

    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   load;
    logic                   complete;
    logic                   orphan_hit;
    logic                   dup_hit;
    logic [NUM_THREADS-1:0] head_mask;
    logic [NUM_THREADS-1:0] acc;
    logic [DATA_W-1:0]      merged;
    logic [DATA_W-1:0]      packet_data;

    always_comb begin
        empty      = (count == CNT_W'(0));
        full       = (count == CNT_W'(TAG_DEPTH));
        push       = tag_valid && !full;
        head_mask  = empty ? '0 : mask_mem[rd_ptr];
        acc        = empty ? '0 : (core_done & head_mask & ~collected);
        complete   = !empty && (((collected | acc) & head_mask) == head_mask);
        load       = complete && (!wb_valid || wb_ready);
        orphan_hit = empty ? (|core_done) : (|(core_done & ~head_mask));
        dup_hit    = !empty && (|(core_done & collected));
    end

    // Merge this cycle's accepted lanes over the buffer; unmasked lanes read as zero
    always_comb begin
        merged      = coll_buf;
        packet_data = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (acc[i]) begin
                merged[i*W +: W] = core_result[i*W +: W];
            end
            if (head_mask[i]) begin
                packet_data[i*W +: W] = merged[i*W +: W];
            end
        end
    end

    assign tag_ready    = !full;
    assign collect_hold = complete && wb_valid && !wb_ready;
    assign outstanding  = count;

    // Tag payload memory; contents are only consumed while the FIFO holds them
    always_ff @(posedge clk) begin
        if (push) begin
            warp_mem[wr_ptr] <= tag_warp_id;
            reg_mem[wr_ptr]  <= tag_dest_reg;
            mask_mem[wr_ptr] <= tag_mask;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Lane collection for the head tag; a pop restarts collection for the next head
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_buf  <= '0;
            collected <= '0;
        end else begin
            coll_buf <= merged;
            if (load) begin
                collected <= '0;
            end else begin
                collected <= collected | acc;
            end
        end
    end

    // Writeback output register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_warp_id  <= '0;
            wb_dest_reg <= '0;
            wb_mask     <= '0;
            wb_data     <= '0;
        end else if (load) begin
            wb_valid    <= 1'b1;
            wb_warp_id  <= warp_mem[rd_ptr];
            wb_dest_reg <= reg_mem[rd_ptr];
            wb_mask     <= head_mask;
            wb_data     <= packet_data;
        end else if (wb_ready) begin
            wb_valid    <= 1'b0;
        end
    end

    // Sticky protocol error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan <= 1'b0;
            err_dup    <= 1'b0;
        end else begin
            if (orphan_hit) begin
                err_orphan <= 1'b1;
            end
            if (dup_hit) begin
                err_dup <= 1'b1;
            end
        end
    end

endmodule
